// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port and registered status flags.
// Storage is a plain array that is never reset, so it can map onto block RAM.
// The read port uses a registered read. Occupancy is the difference of two wrap-bit
// pointers. Every flag is computed from the next-state occupancy, so the flags
// always agree with count in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);

    // Thresholds sized to the pointer/count width so every comparison has matching widths.
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0] ZERO_CNT  = '0;

    // Storage array; the contents are deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers: the low bits index the array, and the MSB is the wrap bit.
    logic [ADDR_WIDTH:0]   wr_ptr_reg;
    logic [ADDR_WIDTH:0]   wr_ptr_next;
    logic [ADDR_WIDTH:0]   rd_ptr_reg;
    logic [ADDR_WIDTH:0]   rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH:0]   count_next;

    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  rd_valid_reg;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  almost_full_reg;
    logic                  almost_empty_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;

    logic                  rd_accept;
    logic                  wr_accept;

    // Accept decisions, next pointers and next occupancy.
    // A read into an empty FIFO is refused, even if a write arrives in the same cycle.
    // A write into a full FIFO goes ahead only when a read frees a slot on the same edge.
    always_comb begin
        rd_accept   = rd_en && !empty_reg;
        wr_accept   = wr_en && (!full_reg || rd_accept);
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        // The modulo-2^(ADDR_WIDTH+1) difference covers 0..DEPTH thanks to the wrap bit.
        count_next = wr_ptr_next - rd_ptr_next;
    end

    // Array write port. This block has no reset, so it can infer RAM.
    // The write is gated off while reset is asserted, so a write in that cycle is ignored.
    always_ff @(posedge clock) begin
        if (!reset && wr_accept) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Registered read port. rd_data keeps its value whenever no read is accepted.
    // When the FIFO is full, a read and a write can hit the same address together.
    // The read then returns the old word, which is the oldest entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else if (rd_accept) begin
            rd_data_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    // Pointer, occupancy, status flag and event pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= (AF_CNT == ZERO_CNT);
            almost_empty_reg <= 1'b1;
            rd_valid_reg     <= 1'b0;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            full_reg         <= (count_next == DEPTH_CNT);
            empty_reg        <= (count_next == ZERO_CNT);
            almost_full_reg  <= (count_next >= AF_CNT);
            almost_empty_reg <= (count_next <= AE_CNT);
            rd_valid_reg     <= rd_accept;
            overflow_reg     <= wr_en && !wr_accept;
            underflow_reg    <= rd_en && !rd_accept;
        end
    end

    assign rd_data      = rd_data_reg;
    assign rd_valid     = rd_valid_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scenarios plus a randomized run.
// A queue-based reference model computes the expected outputs, and they are compared every cycle.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the queue holds the FIFO contents, oldest entry at the front.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rd_data  = '0;
    bit            m_rd_valid = 1'b0;
    bit            m_ovf      = 1'b0;
    bit            m_unf      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model at the edge, then check every output mid-cycle.
    task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit rs);
        int  sz;
        bit  rok;
        bit  wok;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        reset   = rs;
        @(posedge clock);
        sz = q.size();
        if (rs) begin
            q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
        end else begin
            rok        = r && (sz > 0);
            wok        = w && ((sz < DEPTH) || rok);
            m_ovf      = w && !wok;
            m_unf      = r && !rok;
            m_rd_valid = rok;
            if (rok) m_rd_data = q.pop_front();
            if (wok) q.push_back(d);
        end
        @(negedge clock);
        sz = q.size();
        chk("count",        32'(count),        32'(sz));
        chk("empty",        32'(empty),        32'(sz == 0));
        chk("full",         32'(full),         32'(sz == DEPTH));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        chk("almost_full",  32'(almost_full),  32'(sz >= AF));
        chk("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        chk("rd_data",      32'(rd_data),      32'(m_rd_data));
        chk("overflow",     32'(overflow),     32'(m_ovf));
        chk("underflow",    32'(underflow),    32'(m_unf));
        if (rd_valid) $display("read  data=%02h count=%0d", rd_data, count);
    endtask

    initial begin
        logic [DW-1:0] v;
        int wr_pct;
        int rd_pct;

        // Reset for two cycles, then run one idle cycle.
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 0);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_ae",       32'(almost_empty), 32'd1);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_rd_valid", 32'(rd_valid),     32'd0);
        chk("rst_rd_data",  32'(rd_data),      32'd0);

        // Fill the FIFO, push a 17th word to force overflow, then drain it in order.
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'hAA, 0, 0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_full",  32'(full),     32'd1);
        chk("ovf_count", 32'(count),    32'd16);
        cycle(0, 8'h00, 0, 0);
        chk("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 8'h00, 1, 0);
            chk("drain_data", 32'(rd_data), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // When full, a read and a write in the same cycle both succeed.
        // The written word is checked again after the pointers wrap.
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'h55, 1, 0);
        chk("rw_full_data",  32'(rd_data),  32'h00);
        chk("rw_full_count", 32'(count),    32'd16);
        chk("rw_full_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 8'h00, 1, 0);
            chk("wrap_data", 32'(rd_data), (i == DEPTH - 1) ? 32'h55 : 32'(i + 1));
        end

        // When empty, a same-cycle read is refused but the write still lands.
        cycle(1, 8'h33, 1, 0);
        chk("unf_pulse", 32'(underflow), 32'd1);
        chk("unf_valid", 32'(rd_valid),  32'd0);
        chk("unf_count", 32'(count),     32'd1);
        cycle(0, 8'h00, 1, 0);
        chk("unf_read",  32'(rd_data),   32'h33);

        // Reset mid-operation while wr_en is high.
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        cycle(1, 8'hEE, 0, 1);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        cycle(1, 8'h77, 0, 0);
        cycle(0, 8'h00, 1, 0);
        chk("midrst_read",  32'(rd_data), 32'h77);

        // Occupancy sweep from 0 up to 16 and back down to 0.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1, 8'(8'hC0 + i), 0, 0);
            chk("sweep_up_ae", 32'(almost_empty), 32'(i <= 2));
            chk("sweep_up_af", 32'(almost_full),  32'(i >= 14));
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cycle(0, 8'h00, 1, 0);
            chk("sweep_dn_ae", 32'(almost_empty), 32'(i <= 2));
            chk("sweep_dn_af", 32'(almost_full),  32'(i >= 14));
        end

        // Randomized traffic with drifting write/read bias and rare resets.
        wr_pct = 50;
        rd_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin wr_pct = 85; rd_pct = 25; end
                    1:       begin wr_pct = 25; rd_pct = 85; end
                    default: begin wr_pct = 60; rd_pct = 60; end
                endcase
            end
            v = 8'($urandom);
            cycle(($urandom_range(0, 99) < wr_pct), v,
                  ($urandom_range(0, 99) < rd_pct),
                  ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
